trail_stack: RTL and testbench

TRAIL_STACK -- requirements
Module: trail_stack

---
 rtl/trail_stack.sv | 170 +++++++++++++++++
 tb/tb_trail_stack.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_stack.sv
// trail_stack: assignment trail for a DPLL/CDCL style solver.
//
// Records variable assignments in push order, each tagged as a decision or an
// implied entry. A backtrack request unwinds the trail one entry per cycle:
// implied entries are reported for unassignment, and the newest decision is
// reported with its value inverted, which ends the unwind. Finding no decision
// on the trail leaves the block in an absorbing UNSAT state.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous, active-low
//   en             global enable; 0 freezes state and silences pulses
//   push           append {push_var, push_val, push_is_dec}
//   push_var       variable index to record
//   push_val       assigned value
//   push_is_dec    1 = decision entry, 0 = implied entry
//   backtrack      unwind to and flip the newest decision
//   busy           high while unwinding
//   unassign_valid implied entry popped this cycle (var on unassign_var)
//   flip_valid     decision popped this cycle (var/inverted value on flip_*)
//   unsat          sticky: backtrack found no decision
//   overflow       sticky: push attempted while full
//   count / level  entries held / decision entries held
//   empty / full   count==0 / count==DEPTH
module trail_stack #(
    parameter int MAX_VARS_BITS = 9,
    parameter int DEPTH         = 512,
    parameter int CNT_BITS      = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     push,
    input  logic [MAX_VARS_BITS-1:0] push_var,
    input  logic                     push_val,
    input  logic                     push_is_dec,
    input  logic                     backtrack,
    output logic                     busy,
    output logic                     unassign_valid,
    output logic [MAX_VARS_BITS-1:0] unassign_var,
    output logic                     flip_valid,
    output logic [MAX_VARS_BITS-1:0] flip_var,
    output logic                     flip_val,
    output logic                     unsat,
    output logic                     overflow,
    output logic [CNT_BITS-1:0]      count,
    output logic [CNT_BITS-1:0]      level,
    output logic                     empty,
    output logic                     full
);

    localparam int IDX_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_BITS = MAX_VARS_BITS + 2;

    typedef enum logic [1:0] {
        IDLE,
        UNWIND,
        UNSAT
    } state_t;

    state_t state, state_next;

    // Entry layout: {var, val, is_dec}
    logic [ENTRY_BITS-1:0]    mem [DEPTH];
    logic [IDX_BITS-1:0]      wr_idx;
    logic [IDX_BITS-1:0]      top_idx;
    logic [ENTRY_BITS-1:0]    top_entry;
    logic [MAX_VARS_BITS-1:0] top_var;
    logic                     top_val;
    logic                     top_is_dec;

    logic                wr_en;
    logic [CNT_BITS-1:0] count_next;
    logic [CNT_BITS-1:0] level_next;
    logic                unsat_next;
    logic                overflow_next;

    assign full  = (count == CNT_BITS'(DEPTH));
    assign empty = (count == '0);

    assign wr_idx     = IDX_BITS'(count);
    // Top index is meaningless when count==0; it is never used in that case.
    assign top_idx    = IDX_BITS'(count - CNT_BITS'(1));
    assign top_entry  = mem[top_idx];
    assign top_var    = top_entry[ENTRY_BITS-1:2];
    assign top_val    = top_entry[1];
    assign top_is_dec = top_entry[0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            level    <= '0;
            unsat    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            level    <= level_next;
            unsat    <= unsat_next;
            overflow <= overflow_next;
        end
    end

    // Entry storage is never cleared; count alone defines valid contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= {push_var, push_val, push_is_dec};
        end
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        level_next     = level;
        unsat_next     = unsat;
        overflow_next  = overflow;
        wr_en          = 1'b0;
        unassign_valid = 1'b0;
        flip_valid     = 1'b0;
        unassign_var   = top_var;
        flip_var       = top_var;
        flip_val       = ~top_val;
        busy           = (state == UNWIND) && reset;

        // Reset is folded in so pulses drop in the very cycle it is asserted.
        if (en && reset) begin
            unique case (state)
                IDLE: begin
                    if (push) begin
                        if (!full) begin
                            wr_en      = 1'b1;
                            count_next = count + CNT_BITS'(1);
                            if (push_is_dec) begin
                                level_next = level + CNT_BITS'(1);
                            end
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                    if (backtrack) begin
                        state_next = UNWIND;
                    end
                end
                UNWIND: begin
                    if (count == '0) begin
                        unsat_next = 1'b1;
                        state_next = UNSAT;
                    end else begin
                        count_next = count - CNT_BITS'(1);
                        if (top_is_dec) begin
                            flip_valid = 1'b1;
                            level_next = level - CNT_BITS'(1);
                            state_next = IDLE;
                        end else begin
                            unassign_valid = 1'b1;
                        end
                    end
                end
                UNSAT: begin
                    state_next = UNSAT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trail_stack.sv
module tb_trail_stack;

    localparam int VB = 9;
    localparam int CB = 10;   // $clog2(512+1)
    localparam int CB4 = 3;   // $clog2(4+1)

    logic          clock;
    logic          reset;
    logic          en;
    logic          push;
    logic [VB-1:0] push_var;
    logic          push_val;
    logic          push_is_dec;
    logic          backtrack;

    logic          busy, unassign_valid, flip_valid, flip_val, unsat, overflow, empty, full;
    logic [VB-1:0] unassign_var, flip_var;
    logic [CB-1:0] count, level;

    logic           b_busy, b_unassign_valid, b_flip_valid, b_flip_val, b_unsat, b_overflow, b_empty, b_full;
    logic [VB-1:0]  b_unassign_var, b_flip_var;
    logic [CB4-1:0] b_count, b_level;

    trail_stack #(.MAX_VARS_BITS(VB), .DEPTH(512)) dut (
        .clock(clock), .reset(reset), .en(en), .push(push), .push_var(push_var),
        .push_val(push_val), .push_is_dec(push_is_dec), .backtrack(backtrack),
        .busy(busy), .unassign_valid(unassign_valid), .unassign_var(unassign_var),
        .flip_valid(flip_valid), .flip_var(flip_var), .flip_val(flip_val),
        .unsat(unsat), .overflow(overflow), .count(count), .level(level),
        .empty(empty), .full(full)
    );

    trail_stack #(.MAX_VARS_BITS(VB), .DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .en(en), .push(push), .push_var(push_var),
        .push_val(push_val), .push_is_dec(push_is_dec), .backtrack(backtrack),
        .busy(b_busy), .unassign_valid(b_unassign_valid), .unassign_var(b_unassign_var),
        .flip_valid(b_flip_valid), .flip_var(b_flip_var), .flip_val(b_flip_val),
        .unsat(b_unsat), .overflow(b_overflow), .count(b_count), .level(b_level),
        .empty(b_empty), .full(b_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {OP_RESET, OP_PUSH, OP_BT} op_t;
    typedef struct {
        op_t op;
        int  v;
        bit  val;
        bit  dec;
        int  exp_count;
        int  exp_level;
        bit  exp_unsat;
    } vec_t;
    typedef struct { int v; bit val; bit dec; } ent_t;
    typedef struct { bit is_flip; int v; bit val; } pulse_t;

    vec_t   vecs[$];
    ent_t   mt[$];
    pulse_t exp_q[$];
    int     n_checks = 0;
    int     n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b1; push = 1'b0; backtrack = 1'b0;
        tick(); tick();
        reset = 1'b1;
        mt.delete();
        exp_q.delete();
        @(negedge clock);
    endtask

    task automatic push_one(input int v, input bit val, input bit dec);
        push = 1'b1; push_var = VB'(v); push_val = val; push_is_dec = dec;
        tick();
        push = 1'b0;
        mt.push_back('{v, val, dec});
        @(negedge clock);
    endtask

    // Reference unwinding: expected pulses come from the bench's own trail copy.
    task automatic run_backtrack();
        bit     found;
        ent_t   e;
        pulse_t p;
        int     exp_busy;
        int     busy_cycles;
        found = 1'b0;
        while (mt.size() > 0 && !found) begin
            e = mt.pop_back();
            if (e.dec) begin
                exp_q.push_back('{1'b1, e.v, ~e.val});
                found = 1'b1;
            end else begin
                exp_q.push_back('{1'b0, e.v, 1'b0});
            end
        end
        exp_busy = found ? exp_q.size() : exp_q.size() + 1;
        backtrack = 1'b1;
        tick();
        backtrack = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            if (!busy) break;
            busy_cycles++;
            if (unassign_valid || flip_valid) begin
                if (exp_q.size() == 0) begin
                    check("pulse_unexpected", int'(unassign_valid | flip_valid), 0);
                end else begin
                    p = exp_q.pop_front();
                    check("pulse_kind_flip", int'(flip_valid), int'(p.is_flip));
                    check("pulse_kind_unassign", int'(unassign_valid), int'(!p.is_flip));
                    if (p.is_flip) begin
                        check("flip_var", int'(flip_var), p.v);
                        check("flip_val", int'(flip_val), int'(p.val));
                    end else begin
                        check("unassign_var", int'(unassign_var), p.v);
                    end
                end
            end
            tick();
        end
        check("busy_cycles", busy_cycles, exp_busy);
        check("busy_after_unwind", int'(busy), 0);
        check("pulses_after_unwind", int'(unassign_valid | flip_valid), 0);
        check("pulses_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; push = 1'b0; backtrack = 1'b0;
        push_var = '0; push_val = 1'b0; push_is_dec = 1'b0;

        vecs.push_back('{OP_RESET, 0, 1'b0, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{OP_PUSH,  1, 1'b0, 1'b1, 1, 1, 1'b0});
        vecs.push_back('{OP_PUSH,  2, 1'b1, 1'b0, 2, 1, 1'b0});
        vecs.push_back('{OP_PUSH,  3, 1'b1, 1'b0, 3, 1, 1'b0});
        vecs.push_back('{OP_BT,    0, 1'b0, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{OP_RESET, 0, 1'b0, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{OP_PUSH,  5, 1'b1, 1'b1, 1, 1, 1'b0});
        vecs.push_back('{OP_PUSH,  6, 1'b0, 1'b1, 2, 2, 1'b0});
        vecs.push_back('{OP_BT,    0, 1'b0, 1'b0, 1, 1, 1'b0});
        vecs.push_back('{OP_PUSH,  6, 1'b1, 1'b0, 2, 1, 1'b0});
        vecs.push_back('{OP_BT,    0, 1'b0, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{OP_RESET, 0, 1'b0, 1'b0, 0, 0, 1'b0});
        vecs.push_back('{OP_PUSH,  4, 1'b0, 1'b0, 1, 0, 1'b0});
        vecs.push_back('{OP_BT,    0, 1'b0, 1'b0, 0, 0, 1'b1});

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RESET: do_reset();
                OP_PUSH:  push_one(vecs[i].v, vecs[i].val, vecs[i].dec);
                default:  run_backtrack();
            endcase
            check($sformatf("v%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("v%0d_level", i), int'(level), vecs[i].exp_level);
            check($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].exp_count == 0));
            check($sformatf("v%0d_unsat", i), int'(unsat), int'(vecs[i].exp_unsat));
            check($sformatf("v%0d_busy", i), int'(busy), 0);
            check($sformatf("v%0d_overflow", i), int'(overflow), 0);
        end

        // UNSAT absorbs push and backtrack until reset.
        push_one(9, 1'b1, 1'b1);
        check("unsat_push_count", int'(count), 0);
        check("unsat_push_overflow", int'(overflow), 0);
        backtrack = 1'b1;
        tick();
        backtrack = 1'b0;
        @(negedge clock);
        check("unsat_bt_busy", int'(busy), 0);
        check("unsat_bt_pulses", int'(unassign_valid | flip_valid), 0);
        check("unsat_sticky", int'(unsat), 1);
        do_reset();
        check("unsat_cleared", int'(unsat), 0);

        // Same-cycle push and backtrack: pushed entry is unwound first.
        push = 1'b1; push_var = VB'(8); push_val = 1'b1; push_is_dec = 1'b1; backtrack = 1'b1;
        tick();
        push = 1'b0; backtrack = 1'b0;
        @(negedge clock);
        check("pb_busy", int'(busy), 1);
        check("pb_flip_valid", int'(flip_valid), 1);
        check("pb_flip_var", int'(flip_var), 8);
        check("pb_flip_val", int'(flip_val), 0);
        tick();
        @(negedge clock);
        check("pb_busy_done", int'(busy), 0);
        check("pb_count", int'(count), 0);
        check("pb_level", int'(level), 0);

        // Enable gating: frozen push, then a paused unwind.
        do_reset();
        en = 1'b0;
        push = 1'b1; push_var = VB'(9); push_val = 1'b1; push_is_dec = 1'b1;
        tick();
        push = 1'b0; en = 1'b1;
        @(negedge clock);
        check("en0_push_count", int'(count), 0);
        push_one(1, 1'b1, 1'b1);
        push_one(2, 1'b0, 1'b0);
        backtrack = 1'b1;
        tick();
        backtrack = 1'b0;
        @(negedge clock);
        check("en_unassign_valid", int'(unassign_valid), 1);
        check("en_unassign_var", int'(unassign_var), 2);
        tick();
        en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check($sformatf("en0_c%0d_pulses", c), int'(unassign_valid | flip_valid), 0);
            check($sformatf("en0_c%0d_count", c), int'(count), 1);
            check($sformatf("en0_c%0d_level", c), int'(level), 1);
            check($sformatf("en0_c%0d_busy", c), int'(busy), 1);
            tick();
        end
        en = 1'b1;
        @(negedge clock);
        check("en_resume_flip_valid", int'(flip_valid), 1);
        check("en_resume_flip_var", int'(flip_var), 1);
        check("en_resume_flip_val", int'(flip_val), 0);
        tick();
        @(negedge clock);
        check("en_done_busy", int'(busy), 0);
        check("en_done_count", int'(count), 0);
        check("en_done_level", int'(level), 0);

        // Reset in the middle of an unwind.
        do_reset();
        push_one(1, 1'b0, 1'b1);
        push_one(2, 1'b0, 1'b0);
        push_one(3, 1'b1, 1'b0);
        backtrack = 1'b1;
        tick();
        backtrack = 1'b0;
        @(negedge clock);
        check("rst_first_unassign", int'(unassign_valid), 1);
        check("rst_first_var", int'(unassign_var), 3);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy_low", int'(busy), 0);
        check("rst_pulses_low", int'(unassign_valid | flip_valid), 0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("rst_count", int'(count), 0);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flip", int'(flip_valid), 0);
        tick();
        @(negedge clock);
        check("rst_after_busy", int'(busy), 0);
        check("rst_after_flip", int'(flip_valid), 0);
        mt.delete();

        // Overflow on the 4-deep instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_one(i + 1, 1'b0, 1'b0);
            if (i == 2) check("b_full_after3", int'(b_full), 0);
            if (i == 3) begin
                check("b_full_after4", int'(b_full), 1);
                check("b_overflow_after4", int'(b_overflow), 0);
            end
            if (i == 4) begin
                check("b_overflow_after5", int'(b_overflow), 1);
                check("b_count_after5", int'(b_count), 4);
            end
        end
        tick();
        @(negedge clock);
        check("b_overflow_sticky", int'(b_overflow), 1);
        check("a_no_overflow", int'(overflow), 0);
        check("a_count5", int'(count), 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
